// File: rtl/axi_sram_slave_if.sv
// AXI4 bundle carrying all five channels (4-bit IDs, 32-bit address/data).
// The slave modport is used by axi_sram_slave; the master modport is for initiators.
interface axi_interface;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave: independent write and read burst engines sharing one
// word-wide memory with byte-lane write enables and a registered read port.
module axi_sram_slave #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  axi_interface.slave  s
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (size > 3'd2) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // WRAP keeps the upper bits of the aligned window and advances only the low bits.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~mask) | ((addr + step) & mask);
      default: return addr + step;
    endcase
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return ((addr - BASE) >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'((addr - BASE) >> 2);
  endfunction

  logic        r_live;
  w_state_e    r_w_state, w_w_next;
  r_state_e    r_r_state, w_r_next;

  logic [3:0]  r_aw_id;
  logic [31:0] r_aw_addr;
  logic [7:0]  r_aw_len;
  logic [2:0]  r_aw_size;
  logic [1:0]  r_aw_burst;
  logic [7:0]  r_w_cnt;
  logic        r_w_err;

  logic [3:0]  r_ar_id;
  logic [31:0] r_ar_addr;
  logic [7:0]  r_ar_len;
  logic [2:0]  r_ar_size;
  logic [1:0]  r_ar_burst;
  logic        r_ar_bad;
  logic [7:0]  r_r_cnt;
  logic [31:0] r_rdata;
  logic        r_rresp_err;

  logic [31:0] r_mem [DEPTH];

  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic        w_aw_bad, w_wr_en;
  logic [31:0] w_rd_addr;
  logic        w_rd_bad, w_rd_ok;

  assign w_aw_hs  = s.awvalid && s.awready;
  assign w_w_hs   = s.wvalid  && s.wready;
  assign w_b_hs   = s.bvalid  && s.bready;
  assign w_ar_hs  = s.arvalid && s.arready;
  assign w_r_hs   = s.rvalid  && s.rready;
  assign w_aw_bad = burst_bad(r_aw_len, r_aw_size, r_aw_burst);
  assign w_wr_en  = w_w_hs && !w_aw_bad && in_range(r_aw_addr);

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // ---------------- write path ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_w_state <= W_IDLE;
    else          r_w_state <= w_w_next;
  end

  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_aw_hs)             w_w_next = W_DATA;
      W_DATA:  if (w_w_hs && s.wlast)   w_w_next = W_RESP;
      W_RESP:  if (w_b_hs)              w_w_next = W_IDLE;
      default:                          w_w_next = W_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    s.awready = 1'b0;
    s.wready  = 1'b0;
    s.bvalid  = 1'b0;
    s.bid     = 4'd0;
    s.bresp   = 2'b00;
    case (r_w_state)
      W_IDLE: s.awready = r_live;
      W_DATA: s.wready  = 1'b1;
      W_RESP: begin
        s.bvalid = 1'b1;
        s.bid    = r_aw_id;
        s.bresp  = (r_w_err || w_aw_bad) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_w_cnt    <= '0;
      r_w_err    <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_id    <= s.awid;
        r_aw_addr  <= s.awaddr;
        r_aw_len   <= s.awlen;
        r_aw_size  <= s.awsize;
        r_aw_burst <= s.awburst;
        r_w_cnt    <= '0;
        r_w_err    <= 1'b0;
      end
      if (w_w_hs) begin
        r_aw_addr <= next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
        r_w_cnt   <= r_w_cnt + 8'd1;
        if ((s.wlast != (r_w_cnt == r_aw_len)) || (!w_aw_bad && !in_range(r_aw_addr)))
          r_w_err <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive ARESETn.
  always_ff @(posedge ACLK) begin
    if (w_wr_en)
      for (int b = 0; b < 4; b++)
        if (s.wstrb[b]) r_mem[word_idx(r_aw_addr)][8*b +: 8] <= s.wdata[8*b +: 8];
  end

  // ---------------- read path ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_r_state <= R_IDLE;
    else          r_r_state <= w_r_next;
  end

  always_comb begin
    w_r_next = r_r_state;
    case (r_r_state)
      R_IDLE: if (w_ar_hs)                          w_r_next = R_DATA;
      R_DATA: if (w_r_hs && (r_r_cnt == r_ar_len))  w_r_next = R_IDLE;
      default:                                      w_r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s.arready = 1'b0;
    s.rvalid  = 1'b0;
    s.rid     = 4'd0;
    s.rdata   = 32'd0;
    s.rresp   = 2'b00;
    s.rlast   = 1'b0;
    case (r_r_state)
      R_IDLE: s.arready = r_live;
      R_DATA: begin
        s.rvalid = 1'b1;
        s.rid    = r_ar_id;
        s.rdata  = r_rdata;
        s.rresp  = r_rresp_err ? 2'b10 : 2'b00;
        s.rlast  = (r_r_cnt == r_ar_len);
      end
      default: ;
    endcase
  end

  // The word for a beat is fetched on the handshake that opens it, then held.
  assign w_rd_addr = (r_r_state == R_IDLE) ? s.araddr
                   : next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
  assign w_rd_bad  = (r_r_state == R_IDLE) ? burst_bad(s.arlen, s.arsize, s.arburst) : r_ar_bad;
  assign w_rd_ok   = !w_rd_bad && in_range(w_rd_addr);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ar_id     <= '0;
      r_ar_addr   <= '0;
      r_ar_len    <= '0;
      r_ar_size   <= '0;
      r_ar_burst  <= '0;
      r_ar_bad    <= 1'b0;
      r_r_cnt     <= '0;
      r_rdata     <= '0;
      r_rresp_err <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_ar_id    <= s.arid;
        r_ar_len   <= s.arlen;
        r_ar_size  <= s.arsize;
        r_ar_burst <= s.arburst;
        r_ar_bad   <= w_rd_bad;
        r_r_cnt    <= '0;
      end
      if (w_r_hs) r_r_cnt <= r_r_cnt + 8'd1;
      // NOTE: non-blocking writes to r_mem mean a same-edge fetch sees the pre-write word.
      if (w_ar_hs || w_r_hs) begin
        r_ar_addr   <= w_rd_addr;
        r_rdata     <= w_rd_ok ? r_mem[word_idx(w_rd_addr)] : 32'd0;
        r_rresp_err <= !w_rd_ok;
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed bursts plus random traffic
// scored against a word-array model with burst addresses computed arithmetically.
module tb_axi_sram_slave;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_interface s_if ();

  axi_sram_slave #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .ACLK    (aclk),
    .ARESETn (aresetn),
    .s       (s_if.slave)
  );

  logic [31:0] model [DEPTH];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bad_burst(input int len, input int size, input logic [1:0] burst);
    return (burst == 2'b11) || (size > 2) || (burst == 2'b10 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return ((a - BASE) / 4) < DEPTH;
  endfunction

  // Address of beat i: the start plus i transfers, folded into the aligned window for WRAP.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len, input int size,
                                            input logic [1:0] burst, input int i);
    logic [31:0] bytes, total, lower;
    bytes = 32'(1 << size);
    total = 32'(len + 1) * bytes;
    if (burst == 2'b00) return start;
    if (burst == 2'b01) return start + 32'(i) * bytes;
    lower = (start / total) * total;
    return lower + ((start - lower + 32'(i) * bytes) % total);
  endfunction

  task automatic pulse_reset();
    aresetn = 1'b0;
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.wlast = 1'b0; s_if.bready = 1'b0;
    s_if.arvalid = 1'b0; s_if.rready = 1'b0;
    #1;
    check("rst_awready", s_if.awready, 0);
    check("rst_wready",  s_if.wready,  0);
    check("rst_arready", s_if.arready, 0);
    check("rst_bvalid",  s_if.bvalid,  0);
    check("rst_rvalid",  s_if.rvalid,  0);
    check("rst_rlast",   s_if.rlast,   0);
    check("rst_ids_resp", {s_if.bid, s_if.rid, s_if.bresp, s_if.rresp}, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready", s_if.awready, 1);
    check("rel_arready", s_if.arready, 1);
  endtask

  // Sends the beats queued in wd_q/ws_q; wlast goes on the final queued beat.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst, input int bdelay,
                          input int abort_at);
    int t, nb;
    logic bad, exp_err;
    logic [31:0] a, idx;
    nb = wd_q.size();
    bad = bad_burst(len, size, burst);
    exp_err = bad;
    s_if.awid = id; s_if.awaddr = addr; s_if.awlen = 8'(len);
    s_if.awsize = 3'(size); s_if.awburst = burst; s_if.awvalid = 1'b1;
    t = 0;
    while (s_if.awready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    check("aw_wait", 32'(t < 50), 1);
    @(negedge aclk);
    s_if.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        pulse_reset();
        wd_q.delete(); ws_q.delete();
        return;
      end
      a = beat_addr(addr, len, size, burst, i);
      s_if.wdata = wd_q[i]; s_if.wstrb = ws_q[i]; s_if.wlast = (i == nb - 1); s_if.wvalid = 1'b1;
      t = 0;
      while (s_if.wready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
      check("w_wait", 32'(t < 50), 1);
      if (!bad && addr_ok(a)) begin
        idx = (a - BASE) / 4;
        for (int b = 0; b < 4; b++)
          if (ws_q[i][b]) model[idx][8*b +: 8] = wd_q[i][8*b +: 8];
      end else if (!bad) exp_err = 1'b1;
      if ((i == nb - 1) != (i == len)) exp_err = 1'b1;
      @(negedge aclk);
    end
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    t = 0;
    while (s_if.bvalid !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    check("b_wait", 32'(t < 50), 1);
    check("bid",   s_if.bid,   id);
    check("bresp", s_if.bresp, exp_err ? 2 : 0);
    if (bdelay > 0) begin
      repeat (bdelay) @(negedge aclk);
      check("bid_hold",   s_if.bid,   id);
      check("bresp_hold", s_if.bresp, exp_err ? 2 : 0);
    end
    s_if.bready = 1'b1;
    @(negedge aclk);
    s_if.bready = 1'b0;
    check("b_single", s_if.bvalid, 0);
    wd_q.delete(); ws_q.delete();
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst, input logic rand_ready,
                         input int abort_at, output logic [31:0] first);
    int t, beat;
    logic bad, ok, stalled, rr;
    logic [31:0] a, exp_d, hold_d;
    logic [6:0]  hold_c;
    first = '0;
    hold_d = '0;
    hold_c = '0;
    bad = bad_burst(len, size, burst);
    s_if.arid = id; s_if.araddr = addr; s_if.arlen = 8'(len);
    s_if.arsize = 3'(size); s_if.arburst = burst; s_if.arvalid = 1'b1;
    t = 0;
    while (s_if.arready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    check("ar_wait", 32'(t < 50), 1);
    @(negedge aclk);
    s_if.arvalid = 1'b0;
    beat = 0; t = 0; stalled = 1'b0;
    while (beat <= len && t < 1000) begin
      rr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_if.rvalid === 1'b1) begin
        if (beat == abort_at) begin
          pulse_reset();
          return;
        end
        if (!stalled) begin
          a = beat_addr(addr, len, size, burst, beat);
          ok = !bad && addr_ok(a);
          exp_d = ok ? model[(a - BASE) / 4] : 32'd0;
          check("rdata", s_if.rdata, exp_d);
          check("rresp", s_if.rresp, ok ? 0 : 2);
          check("rlast", s_if.rlast, 32'(beat == len));
          check("rid",   s_if.rid,   id);
          if (beat == 0) first = s_if.rdata;
          hold_d = s_if.rdata;
          hold_c = {s_if.rid, s_if.rresp, s_if.rlast};
        end else begin
          check("rdata_hold", s_if.rdata, hold_d);
          check("rctl_hold",  {s_if.rid, s_if.rresp, s_if.rlast}, hold_c);
        end
        stalled = !rr;
        if (rr) beat++;
      end
      s_if.rready = rr;
      @(negedge aclk);
      t++;
    end
    s_if.rready = 1'b0;
    check("r_beats", beat, len + 1);
    check("r_done",  s_if.rvalid, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int len, size, bsel, nb;
    logic [1:0] burst;
    logic [31:0] addr;
    int wrap_lens [4] = '{1, 3, 7, 15};

    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
    s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
    s_if.arburst = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
    @(negedge aclk);
    pulse_reset();

    // Fill the whole array so every later read has a known expectation.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
      do_write(4'd0, 32'(k * 1024), 255, 2, 2'b01, 0, -1);
    end

    // INCR write and read-back.
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hA0 + 32'(i)); ws_q.push_back(4'hF); end
    do_write(4'd3, 32'h10, 3, 2, 2'b01, 0, -1);
    do_read(4'd3, 32'h10, 3, 2, 2'b01, 1'b0, -1, d);
    check("incr_first", d, 32'hA0);

    // WRAP read starting mid-window.
    do_read(4'd5, 32'h18, 3, 2, 2'b10, 1'b0, -1, d);
    check("wrap_first", d, 32'hA2);

    // Byte strobes merge into an existing word.
    wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'hF);
    do_write(4'd1, 32'h40, 0, 2, 2'b01, 0, -1);
    wd_q.push_back(32'h1234_5678); ws_q.push_back(4'b0101);
    do_write(4'd1, 32'h40, 0, 2, 2'b01, 0, -1);
    do_read(4'd1, 32'h40, 0, 2, 2'b01, 1'b0, -1, d);
    check("strb_merge", d, 32'hFF34_FF78);

    // Burst running off the top of the array; word 0 must not alias.
    wd_q.push_back(32'hDEAD_0001); ws_q.push_back(4'hF);
    wd_q.push_back(32'hDEAD_0002); ws_q.push_back(4'hF);
    do_write(4'd2, BASE + 32'hFFC, 1, 2, 2'b01, 0, -1);
    do_read(4'd2, BASE + 32'hFFC, 1, 2, 2'b01, 1'b0, -1, d);
    do_read(4'd2, BASE, 0, 2, 2'b01, 1'b0, -1, d);

    // Illegal burst encodings.
    wd_q.push_back(32'h5555_5555); ws_q.push_back(4'hF);
    wd_q.push_back(32'h6666_6666); ws_q.push_back(4'hF);
    do_write(4'd4, 32'h80, 1, 2, 2'b11, 0, -1);
    for (int i = 0; i < 3; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    do_write(4'd4, 32'h80, 2, 2, 2'b10, 0, -1);
    do_read(4'd4, 32'h80, 2, 2, 2'b10, 1'b0, -1, d);
    do_read(4'd4, 32'h80, 1, 3, 2'b01, 1'b0, -1, d);
    do_read(4'd4, 32'h80, 3, 2, 2'b01, 1'b0, -1, d);

    // wlast too early, then missing at the declared last beat.
    for (int i = 0; i < 2; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    do_write(4'd6, 32'h100, 3, 2, 2'b01, 0, -1);
    for (int i = 0; i < 4; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    do_write(4'd6, 32'h120, 1, 2, 2'b01, 0, -1);
    do_read(4'd6, 32'h100, 7, 2, 2'b01, 1'b0, -1, d);
    do_read(4'd6, 32'h120, 3, 2, 2'b01, 1'b0, -1, d);

    // Backpressure on both response channels.
    for (int i = 0; i < 8; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    do_write(4'd7, 32'h200, 7, 2, 2'b01, 5, -1);
    do_read(4'd7, 32'h200, 7, 2, 2'b01, 1'b1, -1, d);

    // Reset mid-write keeps the beats already accepted.
    for (int i = 0; i < 4; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    do_write(4'd8, 32'h300, 3, 2, 2'b01, 0, 2);
    do_read(4'd8, 32'h300, 3, 2, 2'b01, 1'b0, -1, d);

    // Reset during beat 2 of a len-7 read, then a clean read.
    do_read(4'd9, 32'h200, 7, 2, 2'b01, 1'b0, 1, d);
    do_read(4'd9, 32'h200, 7, 2, 2'b01, 1'b1, -1, d);

    // Random legal traffic, narrow sizes included.
    for (int n = 0; n < 40; n++) begin
      size  = $urandom_range(0, 2);
      bsel  = $urandom_range(0, 2);
      burst = 2'(bsel);
      len   = (burst == 2'b10) ? wrap_lens[$urandom_range(0, 3)] : $urandom_range(0, 7);
      addr  = BASE + 32'($urandom_range(0, 200) * 4);
      if (size == 0) addr = addr + 32'($urandom_range(0, 3));
      if (size == 1) addr = addr + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 1) == 1) begin
        nb = len + 1;
        for (int i = 0; i < nb; i++) begin
          wd_q.push_back($urandom);
          ws_q.push_back(4'($urandom_range(0, 15)));
        end
        do_write(4'($urandom_range(0, 15)), addr, len, size, burst, $urandom_range(0, 5), -1);
      end else begin
        do_read(4'($urandom_range(0, 15)), addr, len, size, burst, 1'b1, -1, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit memory words (power of two, at least 4).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning the byte address of word 0.
REQ-003 SHALL have port ACLK, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETn, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port s, of type axi_interface.slave, carrying all five AXI channels (4-bit IDs, 32-bit address and data, 4-bit strobe).

Function
REQ-006 SHALL implement the write path as the FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-007 In W_IDLE, SHALL drive awready=1; on awvalid&awready, SHALL capture awid/awaddr/awlen/awsize/awburst, clear the error flag, and enter W_DATA.
REQ-008 In W_DATA, SHALL drive wready=1; on each handshake, SHALL write bytes where wstrb[i]=1, advance the address, and count beats.
REQ-009 In W_DATA, on the handshake with wlast=1 SHALL enter W_RESP; a wlast arriving before beat awlen, or missing at beat awlen, SHALL set the error flag, and the burst SHALL end on wlast only.
REQ-010 In W_RESP, SHALL drive bvalid=1, bid=captured awid, and bresp=2'b10 if the error flag is set, else 2'b00; on bready SHALL return to W_IDLE.
REQ-011 SHALL implement the read path as the FSM R_IDLE -> R_DATA -> R_IDLE, independent of the write path.
REQ-012 In R_IDLE, SHALL drive arready=1; on handshake SHALL capture the AR fields and enter R_DATA, with rvalid rising the next cycle.
REQ-013 In R_DATA, SHALL hold rvalid=1, rid=captured arid, and rdata=the word at the current address; rlast=1 SHALL hold only on beat arlen.
REQ-014 In R_DATA, on rvalid&rready SHALL advance to the next beat; the handshake on the rlast beat SHALL return to R_IDLE, so at most one burst per direction is outstanding.
REQ-015 SHALL hold all R outputs stable while rvalid=1 and rready=0; likewise B outputs while bvalid=1 and bready=0.
REQ-016 Address update: FIXED (2'b00) SHALL hold the address; INCR (2'b01) SHALL add 1<<size; WRAP (2'b10) SHALL wrap within an aligned (awlen+1)*(1<<size) byte window.
REQ-017 Burst type 2'b11, size >2, or WRAP with len not in {1,3,7,15} SHALL be treated as an error: the burst completes with SLVERR, writes are suppressed, and rdata=0.
REQ-018 A beat whose word index (addr-BASE)>>2 >= DEPTH SHALL be out of range: the write is dropped and sets the error flag; the read returns rdata=0 with rresp=2'b10 on that beat.
REQ-019 In-range read beats SHALL return rresp=2'b00.
REQ-020 Narrow transfers (size<2) SHALL use the full-word lane layout; the master is responsible for supplying the strobes.
REQ-021 A write and a read to the same word in the same cycle SHALL leave the read returning the pre-write data.
REQ-022 SHALL drive no combinational path from any valid input to any ready output.

Reset
REQ-023 While ARESETn=0, SHALL hold both FSMs in idle and drive awready=wready=arready=bvalid=rvalid=rlast=0 and bid=rid=bresp=rresp=0.
REQ-024 ARESETn deasserting SHALL take effect on the next ACLK edge, after which awready=arready=1.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no response; memory contents SHALL not be reset.
REQ-026 Beats written before the reset SHALL remain in memory.

Verification
REQ-027 INCR write: id 3, addr 0x10, len 3, data 0xA0..0xA3 -> a single B with bid=3, bresp=0; a read of the same burst returns 0xA0..0xA3 with rlast on beat 4.
REQ-028 WRAP read: addr 0x18, len 3, size 2 -> beats read words 0x18, 0x1C, 0x10, 0x14.
REQ-029 Strobes: write 0xFFFFFFFF, then write 0x12345678 with wstrb=4'b0101 -> a read returns 0xFF34FF78.
REQ-030 Out of range (DEPTH=1024): INCR len 1 at BASE+0xFFC -> beat 1 OKAY, beat 2 SLVERR; the write B returns bresp=2'b10 and word 0 is unchanged.
REQ-031 Backpressure: rready toggling randomly and bready delayed 5 cycles -> outputs stay stable while stalled, with no lost or duplicated beats.
REQ-032 Reset during beat 2 of a len-7 read -> rvalid=0 within the reset; a following read succeeds normally.
